dram_bank: RTL and testbench

//   Behavioural model of one DRAM bank: a 2-D storage array of DEVICE_WIDTH-bit

---
 rtl/dram_bank_if.sv | 29 ++
 rtl/dram_bank.sv | 35 +++
 tb/tb_dram_bank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dram_bank_if.sv
// Bank access bus: row/column address, write select and the two data paths.
// Read data is driven back by the bank; everything else comes from the sequencer.
interface dram_bank_if #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5
);
    logic                    rd_o_wr;
    logic [DEVICE_WIDTH-1:0] dqin;
    logic [DEVICE_WIDTH-1:0] dqout;
    logic [CHWIDTH-1:0]      row;
    logic [COLWIDTH-1:0]     column;

    modport master (
        output rd_o_wr,
        output dqin,
        output row,
        output column,
        input  dqout
    );

    modport slave (
        input  rd_o_wr,
        input  dqin,
        input  row,
        input  column,
        output dqout
    );
endinterface

// File: rtl/dram_bank.sv
// One DRAM bank storage array: clocked writes, combinational reads of [row][column].
// Latency: write lands at the clock edge; read data follows the address with zero latency.
// Backpressure: none, one access per cycle is always accepted (writes ignored in reset).
module dram_bank #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    dram_bank_if.slave  bus
);
    localparam int ADDR_W = CHWIDTH + COLWIDTH;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DEVICE_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]       addr;

    // Row-major flattening: every {row, column} pair maps to a distinct cell.
    assign addr = {bus.row, bus.column};

    // Array contents deliberately survive reset; reset only blocks the write port.
    always_ff @(posedge clk) begin
        if (reset_n && bus.rd_o_wr) begin
            mem[addr] <= bus.dqin;
        end
    end

    always_comb begin
        bus.dqout = '0;
        if (reset_n) begin
            bus.dqout = mem[addr];
        end
    end
endmodule

// File: tb/tb_dram_bank.sv
// Self-checking bench for dram_bank: reference array model plus an expected-data queue.
module tb_dram_bank;
    logic clk;
    logic reset_n;

    dram_bank_if bus ();

    dram_bank u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] model [logic [14:0]];
    logic [3:0] exp_q [$];
    string      tag_q [$];
    logic [3:0] burst [8];

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input logic [3:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop_compare();
        logic [3:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            check("sb_underflow", bus.dqout, 4'hx);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, bus.dqout, e);
        end
    endtask

    task automatic wr(input string tag, input logic [4:0] r, input logic [9:0] c, input logic [3:0] d);
        @(negedge clk);
        bus.rd_o_wr = 1'b1;
        bus.row     = r;
        bus.column  = c;
        bus.dqin    = d;
        sb_push(tag, d);
        @(posedge clk);
        #1;
        model[{r, c}] = d;
        sb_pop_compare();
    endtask

    task automatic rd(input string tag, input logic [4:0] r, input logic [9:0] c);
        @(negedge clk);
        bus.rd_o_wr = 1'b0;
        bus.row     = r;
        bus.column  = c;
        bus.dqin    = 4'h0;
        sb_push(tag, model.exists({r, c}) ? model[{r, c}] : 4'h0);
        @(posedge clk);
        #1;
        sb_pop_compare();
    endtask

    initial begin
        burst[0] = 4'h4; burst[1] = 4'h1; burst[2] = 4'h9; burst[3] = 4'h3;
        burst[4] = 4'hD; burst[5] = 4'hD; burst[6] = 4'h5; burst[7] = 4'h2;

        // Reset held with a write pending: output forced low, write blocked.
        reset_n     = 1'b0;
        bus.rd_o_wr = 1'b1;
        bus.dqin    = 4'hF;
        bus.row     = 5'd1;
        bus.column  = 10'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            sb_push("reset_dqout", 4'h0);
            sb_pop_compare();
        end
        @(negedge clk);
        reset_n     = 1'b1;
        bus.rd_o_wr = 1'b0;
        @(posedge clk);
        #1;
        check("reset_write_blocked", {3'b000, (bus.dqout !== 4'hF)}, 4'h1);

        // Burst write then read back.
        for (int i = 0; i < 8; i++) wr("burst_wr", 5'd1, 10'(i), burst[i]);
        for (int i = 0; i < 8; i++) rd("burst_rd", 5'd1, 10'(i));

        // Row isolation.
        wr("iso_wr0", 5'd0, 10'd3, 4'hA);
        wr("iso_wr1", 5'd1, 10'd3, 4'h5);
        rd("iso_rd0", 5'd0, 10'd3);
        rd("iso_rd1", 5'd1, 10'd3);

        // Overwrite with old data visible before the edge, new data after.
        wr("ovw_first", 5'd2, 10'd1023, 4'h6);
        @(negedge clk);
        bus.rd_o_wr = 1'b1;
        bus.dqin    = 4'h9;
        #1;
        check("ovw_pre_edge_old", bus.dqout, 4'h6);
        @(posedge clk);
        #1;
        model[{5'd2, 10'd1023}] = 4'h9;
        check("ovw_post_edge_new", bus.dqout, 4'h9);
        rd("ovw_rd", 5'd2, 10'd1023);
        wr("corner_wr", 5'd31, 10'd1023, 4'hC);
        rd("corner_rd", 5'd31, 10'd1023);
        rd("corner_nbr", 5'd2, 10'd1023);

        // Read-only cycles with dqin toggling must not write.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.rd_o_wr = 1'b0;
            bus.row     = 5'd1;
            bus.column  = 10'd0;
            bus.dqin    = (i % 2 == 0) ? 4'hF : 4'h0;
            sb_push("rdonly_hold", model[{5'd1, 10'd0}]);
            @(posedge clk);
            #1;
            sb_pop_compare();
        end

        // Short reset pulse between edges, data must survive.
        @(posedge clk);
        #1;
        bus.rd_o_wr = 1'b1;
        bus.dqin    = 4'hE;
        reset_n     = 1'b0;
        #2;
        check("midrun_rst_dqout", bus.dqout, 4'h0);
        #1;
        reset_n     = 1'b1;
        bus.rd_o_wr = 1'b0;
        for (int i = 0; i < 8; i++) rd("post_rst_rd", 5'd1, 10'(i));
        rd("post_rst_iso", 5'd0, 10'd3);
        rd("post_rst_corner", 5'd31, 10'd1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
